// File: rtl/mod_wb_sequencer.sv
// mod_wb_sequencer: serialises multi-register writebacks onto one RF write port, with pending-write scoreboard
module mod_wb_sequencer #(
  parameter int NREGS = 16,
  parameter int XLEN = 64,
  parameter int RSP_IDX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic wb_valid,
  output logic wb_ready,
  input  logic wb_dst0_en,
  input  logic wb_dst1_en,
  input  logic [$clog2(NREGS)-1:0] wb_dst0,
  input  logic [$clog2(NREGS)-1:0] wb_dst1,
  input  logic [XLEN-1:0] wb_data0,
  input  logic [XLEN-1:0] wb_data1,
  input  logic [1:0] wb_rsp_op,
  input  logic wb_sim_end,
  input  logic [XLEN-1:0] rf_rsp,
  output logic rf_we,
  output logic [$clog2(NREGS)-1:0] rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  input  logic claim_valid,
  input  logic [$clog2(NREGS)-1:0] claim_reg,
  input  logic [$clog2(NREGS)-1:0] chk_a,
  input  logic [$clog2(NREGS)-1:0] chk_b,
  output logic busy_a,
  output logic busy_b,
  output logic sim_finish
);
  localparam int AW = $clog2(NREGS);
  typedef enum logic [1:0] {IDLE, WSP, WD0, WD1} state_t;
  state_t state, nxt_acc, nxt_step;
  logic [AW-1:0] d0, d1;
  logic [XLEN-1:0] x0, x1;
  logic e0, e1, sim_end, zero_end, fin, accept, sp_req;
  logic [1:0] rsp_op;
  logic [NREGS-1:0] sb, sb_set, sb_clr;
  assign accept = wb_valid && wb_ready;
  assign sp_req = wb_rsp_op == 2'b01 || wb_rsp_op == 2'b10;
  assign nxt_acc = sp_req ? WSP : wb_dst0_en ? WD0 : wb_dst1_en ? WD1 : IDLE;
  assign nxt_step = (state == WSP && e0) ? WD0 : (state != WD1 && e1) ? WD1 : IDLE;
  assign sb_set = claim_valid ? {{(NREGS-1){1'b0}}, 1'b1} << claim_reg : '0;
  assign sb_clr = rf_we ? {{(NREGS-1){1'b0}}, 1'b1} << rf_waddr : '0;
  always_comb begin
    wb_ready = !reset && state == IDLE;
    rf_we = !reset && state != IDLE;
    rf_waddr = reset ? '0 : state == WSP ? AW'(RSP_IDX) : state == WD0 ? d0 : state == WD1 ? d1 : '0;
    rf_wdata = reset ? '0
             : state == WSP ? (rsp_op == 2'b01 ? rf_rsp + XLEN'(8) : rf_rsp - XLEN'(8))
             : state == WD0 ? x0 : state == WD1 ? x1 : '0;
    busy_a = !reset && sb[chk_a];
    busy_b = !reset && sb[chk_b];
    sim_finish = !reset && fin;
  end
  // a zero-write request with sim_end finishes one edge after acceptance, like a one-write request
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      d0 <= '0;
      d1 <= '0;
      x0 <= '0;
      x1 <= '0;
      e0 <= 1'b0;
      e1 <= 1'b0;
      rsp_op <= 2'b00;
      sim_end <= 1'b0;
      zero_end <= 1'b0;
      fin <= 1'b0;
      sb <= '0;
    end else begin
      sb <= (sb & ~sb_clr) | sb_set;
      zero_end <= accept && nxt_acc == IDLE && wb_sim_end;
      if (zero_end || (state != IDLE && nxt_step == IDLE && sim_end)) fin <= 1'b1;
      if (state == IDLE) begin
        state <= accept ? nxt_acc : IDLE;
        if (accept) begin
          d0 <= wb_dst0;
          d1 <= wb_dst1;
          x0 <= wb_data0;
          x1 <= wb_data1;
          e0 <= wb_dst0_en;
          e1 <= wb_dst1_en;
          rsp_op <= wb_rsp_op;
          sim_end <= wb_sim_end;
        end
      end else state <= nxt_step;
    end
  end
endmodule

// File: tb/tb_mod_wb_sequencer.sv
// tb_mod_wb_sequencer: directed checks of write ordering, RSP adjust, scoreboard, sim_finish and reset
module tb_mod_wb_sequencer;
  logic clk = 0, reset = 1;
  logic wb_valid = 0, wb_ready, wb_dst0_en = 0, wb_dst1_en = 0, wb_sim_end = 0;
  logic [3:0] wb_dst0 = 0, wb_dst1 = 0, rf_waddr, claim_reg = 0, chk_a = 3, chk_b = 5;
  logic [63:0] wb_data0 = 0, wb_data1 = 0, rf_rsp = 0, rf_wdata;
  logic [1:0] wb_rsp_op = 0;
  logic rf_we, claim_valid = 0, busy_a, busy_b, sim_finish;
  int checks = 0, failures = 0;

  mod_wb_sequencer dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_dst0_en(wb_dst0_en), .wb_dst1_en(wb_dst1_en), .wb_dst0(wb_dst0), .wb_dst1(wb_dst1),
    .wb_data0(wb_data0), .wb_data1(wb_data1), .wb_rsp_op(wb_rsp_op), .wb_sim_end(wb_sim_end),
    .rf_rsp(rf_rsp), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .claim_valid(claim_valid), .claim_reg(claim_reg), .chk_a(chk_a), .chk_b(chk_b),
    .busy_a(busy_a), .busy_b(busy_b), .sim_finish(sim_finish)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input string tag, input logic [3:0] a, input logic [63:0] d);
    #1;
    chk({tag, "_we"}, 64'(rf_we), 64'd1);
    chk({tag, "_addr"}, 64'(rf_waddr), 64'(a));
    chk({tag, "_data"}, rf_wdata, d);
    chk({tag, "_ready"}, 64'(wb_ready), 64'd0);
  endtask

  task automatic idle(input string tag);
    #1;
    chk({tag, "_ready"}, 64'(wb_ready), 64'd1);
    chk({tag, "_we"}, 64'(rf_we), 64'd0);
    chk({tag, "_addr"}, 64'(rf_waddr), 64'd0);
    chk({tag, "_data"}, rf_wdata, 64'd0);
  endtask

  task automatic req(input logic [1:0] op, input logic e0, input logic [3:0] a0, input logic [63:0] v0,
                     input logic e1, input logic [3:0] a1, input logic [63:0] v1, input logic se);
    wb_valid = 1; wb_rsp_op = op; wb_dst0_en = e0; wb_dst0 = a0; wb_data0 = v0;
    wb_dst1_en = e1; wb_dst1 = a1; wb_data1 = v1; wb_sim_end = se;
  endtask

  initial begin
    #2;
    chk("rst_ready", 64'(wb_ready), 64'd0);
    chk("rst_we", 64'(rf_we), 64'd0);
    chk("rst_fin", 64'(sim_finish), 64'd0);
    tick;
    reset = 0;
    idle("post_rst");
    // POP r3 with a claim on r3
    req(2'b01, 1, 3, 64'hAB, 0, 0, 0, 0);
    claim_valid = 1; claim_reg = 3;
    tick;
    wb_valid = 0; claim_valid = 0; rf_rsp = 64'h1000;
    wr("pop_sp", 4, 64'h1008);
    chk("sb_set", 64'(busy_a), 64'd1);
    tick;
    wr("pop_d0", 3, 64'hAB);
    chk("sb_hold", 64'(busy_a), 64'd1);
    tick;
    idle("pop_done");
    chk("sb_clr", 64'(busy_a), 64'd0);
    // MUL r0/r2
    req(2'b00, 1, 0, 64'h5, 1, 2, 64'h7, 0);
    tick;
    wb_valid = 0;
    wr("mul_d0", 0, 64'h5);
    tick;
    wr("mul_d1", 2, 64'h7);
    tick;
    idle("mul_done");
    // pop %rsp
    req(2'b01, 1, 4, 64'h2000, 0, 0, 0, 0);
    tick;
    wb_valid = 0;
    wr("poprsp_sp", 4, 64'h1008);
    tick;
    wr("poprsp_d0", 4, 64'h2000);
    tick;
    idle("poprsp_done");
    // PUSH wrapping from zero
    req(2'b10, 0, 0, 0, 0, 0, 0, 0);
    rf_rsp = 64'h0;
    tick;
    wb_valid = 0;
    wr("push_wrap", 4, 64'hFFFF_FFFF_FFFF_FFF8);
    tick;
    idle("push_done");
    // op 11 with same-register destinations: no RSP write, data1 lands last
    req(2'b11, 1, 6, 64'h11, 1, 6, 64'h22, 0);
    tick;
    wb_valid = 0;
    wr("same_d0", 6, 64'h11);
    tick;
    wr("same_d1", 6, 64'h22);
    tick;
    idle("same_done");
    // back-to-back zero-write requests, second ends simulation
    req(2'b00, 0, 0, 0, 0, 0, 0, 0);
    tick;
    idle("zero1");
    wb_sim_end = 1;
    tick;
    wb_valid = 0; wb_sim_end = 0;
    idle("zero2");
    chk("fin_early", 64'(sim_finish), 64'd0);
    tick;
    chk("fin_rise", 64'(sim_finish), 64'd1);
    tick;
    tick;
    chk("fin_sticky", 64'(sim_finish), 64'd1);
    // claim of r3 coinciding with the r3 write: set wins
    req(2'b00, 1, 3, 64'h1, 0, 0, 0, 0);
    tick;
    wb_valid = 0; claim_valid = 1; claim_reg = 3;
    wr("race_wr", 3, 64'h1);
    tick;
    claim_valid = 0;
    #1;
    chk("race_busy_a", 64'(busy_a), 64'd1);
    chk("race_busy_b", 64'(busy_b), 64'd0);
    // reset during WSP of a POP drops the r3 write
    req(2'b01, 1, 3, 64'hAB, 0, 0, 0, 0);
    rf_rsp = 64'h1000;
    tick;
    wb_valid = 0;
    wr("rstmid_sp", 4, 64'h1008);
    reset = 1;
    #1;
    chk("rstmid_we", 64'(rf_we), 64'd0);
    chk("rstmid_ready", 64'(wb_ready), 64'd0);
    chk("rstmid_fin", 64'(sim_finish), 64'd0);
    tick;
    reset = 0;
    chk_b = 4;
    idle("rstmid_after");
    chk("rstmid_sb_a", 64'(busy_a), 64'd0);
    chk("rstmid_sb_b", 64'(busy_b), 64'd0);
    chk("rstmid_fin2", 64'(sim_finish), 64'd0);
    tick;
    idle("rstmid_nowrite");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mod_wb_sequencer.md
# mod_wb_sequencer

Writeback sequencer and register-file write-port scheduler, placed between the EX/WB pipeline register and the 16×64 architectural register file. Instructions that update several registers arrive as one request: MUL/DIV writing RAX and RDX, POP writing RSP and a destination, PUSH/CALL/RET adjusting RSP. The block serialises these updates onto the register file's single write port, one write per cycle. It also keeps a per-register pending-write scoreboard that decode uses for RAW-hazard stalls, and it raises the simulation-end request after the final write of the marked instruction.

## Interface
- `NREGS`, 16: number of architectural registers; register index width is 4.
- `XLEN`, 64: register data width.
- `RSP_IDX`, 4: register index of the stack pointer.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `wb_valid`  in  1  writeback request present.
- `wb_ready`  out  1  the block accepts a request this cycle. A request is accepted when `wb_valid` and `wb_ready` are both high.
- `wb_dst0_en`, `wb_dst1_en`  in  1 each  enable for destination 0 / destination 1.
- `wb_dst0`, `wb_dst1`  in  4 each  destination register indices.
- `wb_data0`, `wb_data1`  in  XLEN each  data for destination 0 / destination 1.
- `wb_rsp_op`  in  2  stack-pointer adjust: 00 none, 01 +8, 10 −8, 11 treated as none.
- `wb_sim_end`  in  1  this instruction ends the simulation.
- `rf_rsp`  in  XLEN  current register-file RSP value (combinational read port).
- `rf_we`  out  1  register-file write enable.
- `rf_waddr`  out  4  register-file write index.
- `rf_wdata`  out  XLEN  register-file write data.
- `claim_valid`  in  1  decode is issuing an instruction that will write a register.
- `claim_reg`  in  4  register claimed by that instruction.
- `chk_a`, `chk_b`  in  4 each  source registers queried by decode.
- `busy_a`, `busy_b`  out  1 each  scoreboard bit for `chk_a` / `chk_b`.
- `sim_finish`  out  1  sticky simulation-end flag.

## Operation
- **States:** IDLE, WSP, WD0, WD1.
- **IDLE**
  - `wb_ready`=1.
  - On acceptance, capture all `wb_*` fields into holding registers.
  - Next state is the first enabled step in the fixed order WSP → WD0 → WD1. WSP is enabled when `wb_rsp_op` is 01 or 10.
  - If no step is enabled, stay in IDLE. Only `sim_end` is processed in that case.
- **WSP**
  - `rf_we`=1, `rf_waddr`=`RSP_IDX`.
  - `rf_wdata` = `rf_rsp` ± 8, computed combinationally this cycle, modulo 2^64 (wraps silently).
- **WD0 / WD1**
  - `rf_we`=1, with the captured index and data.
  - Because the order is fixed, a destination equal to RSP overwrites the adjust. This gives the architectural result for `pop %rsp`.
- **Step transitions:** after each write step, advance to the next enabled step, or to IDLE if none remains. `wb_ready` is 0 in every non-IDLE state.
- **Same-register destinations:** if both destinations name the same register, both writes occur and `wb_data1` is the final value.
- **Outside write states:** `rf_we`=0; `rf_waddr` and `rf_wdata` are 0.
- **Scoreboard:** one bit per register.
  - Set on `claim_valid` for `claim_reg`.
  - Cleared when `rf_we` writes that index.
  - If a claim and a clear hit the same register in the same cycle, the set wins.
  - `busy_a`/`busy_b` read the flopped bits combinationally. There is no bypass of a same-cycle claim.
- **Simulation end:** if the captured `sim_end`=1, `sim_finish` rises on the edge that leaves the last write step. For a zero-write request it rises on the edge after acceptance. It then holds until `reset`.
- **Reset:**
  - The FSM goes to IDLE, holding registers and scoreboard clear, `sim_finish`=0.
  - All outputs are 0 during the reset cycle, including `wb_ready`.
  - Reset asserted mid-sequence drops the remaining writes.

## Timing
- A request accepted at edge T performs its first write in the cycle after T.
- A request with k writes (k = 0..3) produces writes in k consecutive cycles. `wb_ready` returns high in the cycle after the last write.
- Throughput:
  - One request per cycle when every request has zero writes.
  - Otherwise k+1 cycles per request.
- The register file samples `rf_we`/`rf_waddr`/`rf_wdata` on the same edge that moves the FSM. Write data for WD0/WD1 comes from flops.
- WSP data depends combinationally on `rf_rsp`. The register file must present the value as of the start of that cycle.
- A scoreboard bit set at edge T is visible on `busy_*` after T. A bit cleared by a write in cycle C reads 0 from the cycle after C.

## Test plan
- **POP (rsp op=01, dst0=3 enabled).** Start with `rf_rsp`=0x1000, data0=0xAB. Required response: cycle 1 writes r4=0x1008, cycle 2 writes r3=0xAB, `wb_ready` is high again in cycle 3.
- **MUL (dst0=0, dst1=2 enabled, data 0x5/0x7).** Required response: writes r0=0x5 then r2=0x7 in consecutive cycles, with no RSP write.
- **`pop %rsp` (rsp op=01, dst0=4, data0=0x2000, `rf_rsp`=0x1000).** Required response: r4=0x1008, then r4=0x2000.
- **Boundary cases.**
  - PUSH with `rf_rsp`=0x0 writes r4=0xFFFF_FFFF_FFFF_FFF8 (wrap).
  - A zero-write request is accepted with `wb_ready` held high.
  - A zero-write request with `wb_sim_end`=1 raises `sim_finish` one cycle later.
- **Scoreboard.**
  - Claim r3, then check: `busy_a`=1 until the cycle after the r3 write, then 0.
  - A claim of r3 in the same cycle as a write to r3 leaves busy=1.
- **Reset mid-sequence.** Assert `reset` during WSP of a POP. Required response: no r3 write occurs, the scoreboard reads all zero, and `wb_ready`=1 in the cycle after reset deasserts.
